// File: rtl/rally_pkg.sv
// Shared rally-game definitions: heading encoding, car-mover FSM states and
// screen geometry.
package rally_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam int unsigned SCREEN_W  = 640;
    localparam int unsigned SCREEN_H  = 480;
    localparam int unsigned TILE_SIZE = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_PROBE0,
        S_PROBE1,
        S_PROBE2,
        S_PROBE3,
        S_COMMIT
    } mover_state_t;

    // Opposite heading: up<->down, right<->left.
    function automatic logic [1:0] reverse_dir(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/car_mover_if.sv
// Pixel-probe bus between the car mover (master) and the map wall lookup (slave).
interface car_mover_if;

    logic [9:0] probe_x;
    logic [9:0] probe_y;
    logic       probe_is_wall;

    modport master (
        output probe_x,
        output probe_y,
        input  probe_is_wall
    );

    modport slave (
        input  probe_x,
        input  probe_y,
        output probe_is_wall
    );

endinterface

// File: rtl/car_mover_probe_addr_gen.sv
// Maps a candidate top-left position and probe index to one bounding-box corner.
// Index bit 0 selects the right edge, bit 1 the bottom edge.
module probe_addr_gen #(
    parameter int unsigned CAR_SIZE = 16
) (
    input  logic [9:0] i_cx,
    input  logic [9:0] i_cy,
    input  logic [1:0] i_idx,
    output logic [9:0] o_px,
    output logic [9:0] o_py
);

    localparam logic [9:0] FAR_EDGE = 10'(CAR_SIZE - 1);

    always_comb begin
        o_px = i_idx[0] ? i_cx + FAR_EDGE : i_cx;
        o_py = i_idx[1] ? i_cy + FAR_EDGE : i_cy;
    end

endmodule

// File: rtl/car_mover.sv
// Player car position/heading owner: per tick, computes a one-step candidate,
// probes four corners through the map and commits or flags a crash.
// Optional: define CAR_BOUNCE_EN to reverse the heading on a rejected move.
module car_mover
    import rally_pkg::*;
#(
    parameter int unsigned CAR_SIZE = 16,
    parameter int unsigned STEP     = 2,
    parameter int unsigned START_X  = 64,
    parameter int unsigned START_Y  = 64,
    parameter int unsigned X_LIMIT  = SCREEN_W,
    parameter int unsigned Y_LIMIT  = SCREEN_H
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              move_en,
    input  logic [1:0]        dir_req,
    input  logic              dir_req_valid,
    car_mover_if.master       map_bus,
    output logic [9:0]        car_x,
    output logic [9:0]        car_y,
    output logic [1:0]        heading,
    output logic              busy,
    output logic              crash
);

    localparam logic [10:0] STEP11  = 11'(STEP);
    localparam logic [11:0] SIZE12  = 12'(CAR_SIZE);
    localparam logic [11:0] XLIM12  = 12'(X_LIMIT);
    localparam logic [11:0] YLIM12  = 12'(Y_LIMIT);
    localparam logic [9:0]  START_X10 = 10'(START_X);
    localparam logic [9:0]  START_Y10 = 10'(START_Y);

    mover_state_t r_state, w_next;

    logic [9:0]  r_car_x, r_car_y;
    logic [1:0]  r_heading;
    logic [9:0]  r_cx, r_cy;
    logic        r_hit;
    logic        r_crash;
    logic [9:0]  r_probe_x, r_probe_y;

    logic [10:0] w_cand_x, w_cand_y;
    logic        w_oob;
    logic [9:0]  w_gen_x, w_gen_y;
    logic [1:0]  w_idx;
    logic        w_load_probe;
    logic [9:0]  w_px, w_py;

    // Candidate is 11-bit two's complement so a step past 0 shows up in bit 10.
    always_comb begin
        w_cand_x = {1'b0, r_car_x};
        w_cand_y = {1'b0, r_car_y};
        case (r_heading)
            DIR_UP:    w_cand_y = {1'b0, r_car_y} - STEP11;
            DIR_RIGHT: w_cand_x = {1'b0, r_car_x} + STEP11;
            DIR_DOWN:  w_cand_y = {1'b0, r_car_y} + STEP11;
            default:   w_cand_x = {1'b0, r_car_x} - STEP11;
        endcase
        w_oob = w_cand_x[10] | w_cand_y[10]
              | (({1'b0, w_cand_x} + SIZE12) > XLIM12)
              | (({1'b0, w_cand_y} + SIZE12) > YLIM12);
    end

    // Corner for the next probe state; PROBE0's corner comes straight from CALC.
    always_comb begin
        w_gen_x      = r_cx;
        w_gen_y      = r_cy;
        w_idx        = 2'd0;
        w_load_probe = 1'b1;
        case (r_state)
            S_CALC: begin
                w_gen_x = w_cand_x[9:0];
                w_gen_y = w_cand_y[9:0];
            end
            S_PROBE0: w_idx = 2'd1;
            S_PROBE1: w_idx = 2'd2;
            S_PROBE2: w_idx = 2'd3;
            default:  w_load_probe = 1'b0;
        endcase
    end

    probe_addr_gen #(
        .CAR_SIZE (CAR_SIZE)
    ) u_probe_addr_gen (
        .i_cx  (w_gen_x),
        .i_cy  (w_gen_y),
        .i_idx (w_idx),
        .o_px  (w_px),
        .o_py  (w_py)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (tick && move_en) w_next = S_CALC;
            S_CALC:   w_next = S_PROBE0;
            S_PROBE0: w_next = S_PROBE1;
            S_PROBE1: w_next = S_PROBE2;
            S_PROBE2: w_next = S_PROBE3;
            S_PROBE3: w_next = S_COMMIT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_car_x   <= START_X10;
            r_car_y   <= START_Y10;
            r_heading <= DIR_RIGHT;
            r_cx      <= '0;
            r_cy      <= '0;
            r_hit     <= 1'b0;
            r_crash   <= 1'b0;
            r_probe_x <= '0;
            r_probe_y <= '0;
        end else begin
            r_crash <= 1'b0;
            if (w_load_probe) begin
                r_probe_x <= w_px;
                r_probe_y <= w_py;
            end
            case (r_state)
                S_IDLE: if (tick && dir_req_valid) r_heading <= dir_req;
                S_CALC: begin
                    r_cx  <= w_cand_x[9:0];
                    r_cy  <= w_cand_y[9:0];
                    r_hit <= w_oob;
                end
                S_PROBE0, S_PROBE1, S_PROBE2, S_PROBE3:
                    r_hit <= r_hit | map_bus.probe_is_wall;
                S_COMMIT: begin
                    if (r_hit) begin
                        r_crash <= 1'b1;
`ifdef CAR_BOUNCE_EN
                        r_heading <= reverse_dir(r_heading);
`endif
                    end else begin
                        r_car_x <= r_cx;
                        r_car_y <= r_cy;
                    end
                end
                default: ;
            endcase
        end
    end

    assign map_bus.probe_x = r_probe_x;
    assign map_bus.probe_y = r_probe_y;
    assign car_x   = r_car_x;
    assign car_y   = r_car_y;
    assign heading = r_heading;
    assign busy    = (r_state != S_IDLE);
    assign crash   = r_crash;

endmodule

// File: tb/tb_car_mover.sv
// Self-checking bench for car_mover: attempt-level reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_car_mover;

    localparam int CAR_SIZE = 16;
    localparam int STEP     = 2;
    localparam int START_X  = 64;
    localparam int START_Y  = 64;
    localparam int X_LIMIT  = 640;
    localparam int Y_LIMIT  = 480;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       tick = 1'b0;
    logic       move_en = 1'b0;
    logic [1:0] dir_req = 2'd0;
    logic       dir_req_valid = 1'b0;
    logic [9:0] car_x, car_y;
    logic [1:0] heading;
    logic       busy, crash;

    int map_mode = 0;
    int n_checks = 0;
    int n_pass   = 0;

    car_mover_if bus ();

    car_mover #(
        .CAR_SIZE (CAR_SIZE),
        .STEP     (STEP),
        .START_X  (START_X),
        .START_Y  (START_Y),
        .X_LIMIT  (X_LIMIT),
        .Y_LIMIT  (Y_LIMIT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .tick          (tick),
        .move_en       (move_en),
        .dir_req       (dir_req),
        .dir_req_valid (dir_req_valid),
        .map_bus       (bus),
        .car_x         (car_x),
        .car_y         (car_y),
        .heading       (heading),
        .busy          (busy),
        .crash         (crash)
    );

    always #5 clk = ~clk;

    // Maps: 0 empty, 1 border walls (x<32 or y<32), 2 wall at x>=100.
    function automatic logic wall_at(input int mode, input logic [9:0] x, input logic [9:0] y);
        case (mode)
            1:       return (x < 10'd32) || (y < 10'd32);
            2:       return x >= 10'd100;
            default: return 1'b0;
        endcase
    endfunction

    assign bus.probe_is_wall = wall_at(map_mode, bus.probe_x, bus.probe_y);

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    int m_x, m_y, m_head, m_phase, m_px, m_py, c_x, c_y;
    bit m_hit, m_crash;

    function automatic int next_head(input int cur, input logic v, input logic [1:0] d);
        return v ? int'(d) : cur;
    endfunction

    function automatic int step_x(input int x, input int h);
        return x + ((h == 1) ? STEP : ((h == 3) ? -STEP : 0));
    endfunction

    function automatic int step_y(input int y, input int h);
        return y + ((h == 2) ? STEP : ((h == 0) ? -STEP : 0));
    endfunction

    function automatic int corner(input int c, input bit far);
        return (c + (far ? CAR_SIZE - 1 : 0)) & 1023;
    endfunction

    function automatic bit verdict(input int mode, input int cx, input int cy);
        bit hit;
        hit = (cx < 0) || (cy < 0) || (cx + CAR_SIZE > X_LIMIT) || (cy + CAR_SIZE > Y_LIMIT);
        for (int k = 0; k < 4; k++)
            if (wall_at(mode, 10'(corner(cx, k[0])), 10'(corner(cy, k[1])))) hit = 1'b1;
        return hit;
    endfunction

    // m_phase: 0 idle, 1 after tick edge, 2..5 probing corners 0..3, 6 deciding.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_x <= START_X; m_y <= START_Y; m_head <= 1; m_phase <= 0;
            m_px <= 0; m_py <= 0; m_crash <= 1'b0; m_hit <= 1'b0;
            c_x <= 0; c_y <= 0;
        end else begin
            m_crash <= 1'b0;
            if (m_phase == 0) begin
                if (tick) begin
                    m_head <= next_head(m_head, dir_req_valid, dir_req);
                    if (move_en) begin
                        c_x <= step_x(m_x, next_head(m_head, dir_req_valid, dir_req));
                        c_y <= step_y(m_y, next_head(m_head, dir_req_valid, dir_req));
                        m_hit <= verdict(map_mode,
                                         step_x(m_x, next_head(m_head, dir_req_valid, dir_req)),
                                         step_y(m_y, next_head(m_head, dir_req_valid, dir_req)));
                        m_phase <= 1;
                    end
                end
            end else if (m_phase == 6) begin
                if (m_hit) begin
                    m_crash <= 1'b1;
`ifdef CAR_BOUNCE_EN
                    m_head <= (m_head + 2) % 4;
`endif
                end else begin
                    m_x <= c_x;
                    m_y <= c_y;
                end
                m_phase <= 0;
            end else begin
                if (m_phase <= 4) begin
                    m_px <= corner(c_x, (m_phase == 2) || (m_phase == 4));
                    m_py <= corner(c_y, m_phase >= 3);
                end
                m_phase <= m_phase + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("car_x",   int'(car_x),       m_x);
        check("car_y",   int'(car_y),       m_y);
        check("heading", int'(heading),     m_head);
        check("busy",    int'(busy),        int'(m_phase != 0));
        check("crash",   int'(crash),       int'(m_crash));
        check("probe_x", int'(bus.probe_x), m_px);
        check("probe_y", int'(bus.probe_y), m_py);
    end

    // ---------------- directed scenarios ----------------
    int rec_px[8];
    int rec_py[8];
    int rec_cx[8];
    int rec_busy, rec_crash;

    // One full attempt: tick, then record outputs on the seven following negedges.
    task automatic attempt(input bit mv, input bit dv, input logic [1:0] d);
        @(negedge clk);
        tick = 1'b1; move_en = mv; dir_req_valid = dv; dir_req = d;
        @(negedge clk);
        tick = 1'b0; move_en = 1'b0; dir_req_valid = 1'b0;
        rec_busy = 0; rec_crash = 0;
        for (int n = 1; n <= 7; n++) begin
            if (n > 1) @(negedge clk);
            rec_px[n] = int'(bus.probe_x);
            rec_py[n] = int'(bus.probe_y);
            rec_cx[n] = int'(car_x);
            if (busy)  rec_busy++;
            if (crash) rec_crash++;
        end
    endtask

    initial begin
        int guard;
        #1 reset_n = 1'b0;
        #1;
        check("rst_car_x", int'(car_x), 64);
        check("rst_car_y", int'(car_y), 64);
        check("rst_heading", int'(heading), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_crash", int'(crash), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Basic move right on an empty map.
        map_mode = 0;
        attempt(1'b1, 1'b0, 2'd0);
        check("t1_busy_cycles", rec_busy, 6);
        check("t1_x_before_commit", rec_cx[6], 64);
        check("t1_x_after_commit", rec_cx[7], 66);
        check("t1_crash", rec_crash, 0);

        // Second tick while busy is ignored, including its direction.
        @(negedge clk);
        tick = 1'b1; move_en = 1'b1; dir_req_valid = 1'b0;
        @(negedge clk);
        tick = 1'b0; move_en = 1'b0;
        repeat (2) @(negedge clk);
        tick = 1'b1; move_en = 1'b1; dir_req_valid = 1'b1; dir_req = 2'd2;
        @(negedge clk);
        tick = 1'b0; move_en = 1'b0; dir_req_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("ign_car_x", int'(car_x), 68);
        check("ign_car_y", int'(car_y), 64);
        check("ign_heading", int'(heading), 1);

        // Reset while probing corner 2 aborts the attempt.
        @(negedge clk);
        tick = 1'b1; move_en = 1'b1;
        @(negedge clk);
        tick = 1'b0; move_en = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_probe2_y", int'(bus.probe_y), 79);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_car_x", int'(car_x), 64);
        check("mid_rst_car_y", int'(car_y), 64);
        check("mid_rst_heading", int'(heading), 1);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_probe_x", int'(bus.probe_x), 0);
        check("mid_rst_probe_y", int'(bus.probe_y), 0);
        @(negedge clk);
        reset_n = 1'b1;
        attempt(1'b1, 1'b0, 2'd0);
        check("post_rst_car_x", int'(car_x), 66);

        // Wall at x>=100: drive right until the crash.
        map_mode = 2;
        repeat (9) attempt(1'b1, 1'b0, 2'd0);
        check("wall_approach_x", int'(car_x), 84);
        attempt(1'b1, 1'b0, 2'd0);
        check("wall_crash_pulse", rec_crash, 1);
        check("wall_crash_x", int'(car_x), 84);
`ifdef CAR_BOUNCE_EN
        check("wall_heading", int'(heading), 3);
        attempt(1'b1, 1'b0, 2'd0);
        check("bounce_car_x", int'(car_x), 82);
        check("bounce_crash", rec_crash, 0);
`else
        check("wall_heading", int'(heading), 1);
        attempt(1'b1, 1'b0, 2'd0);
        check("recrash_car_x", int'(car_x), 84);
        check("recrash_crash", rec_crash, 1);
`endif

        // Border-wall level: move left to x=34, then to the wall edge.
        map_mode = 1;
        guard = 0;
        while (m_x > 34 && guard < 40) begin
            attempt(1'b1, 1'b1, 2'd3);
            guard++;
        end
        check("left_reach_34", int'(car_x), 34);
        attempt(1'b1, 1'b1, 2'd3);
        check("left_probe0_x", rec_px[2], 32);
        check("left_probe1_x", rec_px[3], 47);
        check("left_probe3_y", rec_py[5], 79);
        check("left_commit_32", int'(car_x), 32);
        check("left_no_crash", rec_crash, 0);
        attempt(1'b1, 1'b0, 2'd0);
        check("left_wall_x", int'(car_x), 32);
        check("left_wall_crash", rec_crash, 1);

        // Empty map: reach x=0, then step off-screen.
        map_mode = 0;
        guard = 0;
        while (m_x > 0 && guard < 40) begin
            attempt(1'b1, 1'b1, 2'd3);
            guard++;
        end
        check("edge_reach_0", int'(car_x), 0);
        attempt(1'b1, 1'b1, 2'd3);
        check("oob_probe0_x", rec_px[2], 1022);
        check("oob_car_x", int'(car_x), 0);
        check("oob_crash", rec_crash, 1);

        // move_en=0 tick only updates heading.
        attempt(1'b0, 1'b1, 2'd2);
        check("nomove_heading", int'(heading), 2);
        check("nomove_busy", rec_busy, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/car_mover.md
Name: car_mover

Overview:
- Owns the player car's pixel position and heading.
- On each game tick it computes a candidate position one step along the heading, then probes the four corners of the car's bounding box through the map wall lookup, one corner per cycle.
- If no corner hits a wall, the move is committed; otherwise the move is rejected and a crash is flagged.
- Sits between frame timing/input logic (upstream) and the wall-lookup map block, whose pixel-coordinate inputs it drives and whose is_wall output it consumes.

Parameters:
- CAR_SIZE, 16, car bounding-box side in pixels (power of two, ≤32).
- STEP, 2, pixels moved per tick.
- START_X, 64, reset x position (top-left corner).
- START_Y, 64, reset y position (top-left corner).
- X_LIMIT, 640, screen width in pixels.
- Y_LIMIT, 480, screen height in pixels.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle pulse per frame; starts a move attempt
- move_en  in  1  sampled with tick; 0 = no motion this frame
- dir_req  in  2  requested heading: 0=up, 1=right, 2=down, 3=left
- dir_req_valid  in  1  sampled with tick; loads dir_req into heading
- probe_x  out  10  pixel x presented to map
- probe_y  out  10  pixel y presented to map
- probe_is_wall  in  1  combinational wall answer for probe_x/probe_y
- car_x  out  10  committed top-left x
- car_y  out  10  committed top-left y
- heading  out  2  current heading
- busy  out  1  high while a move attempt is in progress
- crash  out  1  one-cycle pulse when a move is rejected

Behaviour:
- Reset (async, reset_n low):
  - car_x=START_X, car_y=START_Y, heading=1 (right).
  - busy=0, crash=0, probe_x=0, probe_y=0.
  - FSM in IDLE. Asserting reset mid-attempt aborts the attempt with no commit.
- FSM states: IDLE, CALC, PROBE0, PROBE1, PROBE2, PROBE3, COMMIT.
- IDLE:
  - tick=1 with move_en=1 → CALC.
  - If dir_req_valid=1, heading takes dir_req on the same edge.
  - tick=1 with move_en=0 → only the heading update happens; stay in IDLE.
- CALC:
  - Candidate (cx,cy) = car position ± STEP along the (possibly new) heading.
  - Compute in 11 bits. If cx<0, cy<0, cx+CAR_SIZE>X_LIMIT or cy+CAR_SIZE>Y_LIMIT, set the internal hit flag immediately.
  - Clear hit otherwise. Go to PROBE0.
- PROBEk (k=0..3):
  - probe_x/probe_y are registered and hold one corner for the whole state:
    - PROBE0: (cx,cy).
    - PROBE1: (cx+CAR_SIZE-1, cy).
    - PROBE2: (cx, cy+CAR_SIZE-1).
    - PROBE3: (cx+CAR_SIZE-1, cy+CAR_SIZE-1).
  - probe_is_wall is sampled at the edge ending the state and ORed into hit.
  - Probes still run when hit was set in CALC; corner values are truncated to 10 bits and their results are don't-care.
- COMMIT:
  - hit=0 → car_x/car_y load cx/cy.
  - hit=1 → position unchanged and crash pulses high for exactly one cycle, the cycle after COMMIT.
  - Return to IDLE.
- Latency: tick sampled at edge E0; new car_x/car_y are visible after E6. busy=1 from after E0 through E6.
- Ticks arriving while busy=1 are ignored, including their dir_req and move_en.
- Heading changes take effect immediately for the attempt started by the same tick.
- probe_x/probe_y hold their last value in IDLE.

Optional Feature:
- Macro CAR_BOUNCE_EN.
- Defined: on a rejected move, heading is reversed in COMMIT (0↔2, 1↔3), so the next tick moves away from the wall. Position is still unchanged.
- Undefined: heading is unchanged on crash.

Decomposition:
- Shared package rally_pkg holds:
  - the direction encoding constants (DIR_UP/RIGHT/DOWN/LEFT);
  - the FSM state typedef;
  - screen constants (640, 480, 32-pixel tile size).
- One natural sub-module: probe_addr_gen. It is purely combinational: it maps candidate position, CAR_SIZE and the probe index to a corner coordinate. The FSM registers its output.

Test Plan:
- Reset with defaults → car_x=64, car_y=64, heading=1, busy=0, crash=0. After deasserting reset, a tick with heading right and an empty map gives car_x=66 exactly 6 cycles after tick, with busy high for those 6 cycles.
- Level with border walls (x<32 is wall), car at (34,64), tick with dir_req=3 valid → probes x=32 and 47; commit gives car_x=32. Next tick → cx=30 hits the wall; car_x stays 32 and one crash pulse follows.
- Car at (0,64) moving left → cx=-2 is flagged out of range in CALC; position unchanged and crash pulses even if the map returns 0.
- Second tick issued 3 cycles after the first, with dir_req=2 valid → ignored; exactly one move of +2 in x and heading stays 1.
- Assert reset_n low during PROBE2 → outputs return to reset values immediately. The next tick produces a fresh attempt from (64,64).
- With CAR_BOUNCE_EN defined: crash moving right → heading becomes 3, and the next tick decrements car_x by 2. Without the macro, heading stays 1 and the car crashes again.
